// File: rtl/obi_host_pipelined_driver.sv
// OBI host-side driver: one-entry request register on the A-channel,
// outstanding-transaction counter and an in-order tag FIFO that pairs each
// R-channel beat with the direction (we) of the transaction it answers.
module obi_host_pipelined_driver #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned ADDR_W    = 39,
   parameter int unsigned BE_BITS   = DATA_W/8,
   parameter int unsigned MAX_OUTST = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   // host side
   input  logic                         host_req_i,
   input  logic                         host_we_i,
   input  logic [BE_BITS-1:0]           host_be_i,
   input  logic [ADDR_W-1:0]            host_addr_i,
   input  logic [DATA_W-1:0]            host_wdata_i,
   output logic                         host_rdy_o,
   // OBI A-channel
   output logic                         req_o,
   input  logic                         gnt_i,
   output logic                         we_o,
   output logic [BE_BITS-1:0]           be_o,
   output logic [ADDR_W-1:0]            addr_o,
   output logic [DATA_W-1:0]            wdata_o,
   // OBI R-channel
   input  logic                         rvalid_i,
   input  logic [DATA_W-1:0]            rdata_i,
   input  logic                         err_i,
   // in-order response to host
   output logic                         rsp_valid_o,
   output logic                         rsp_we_o,
   output logic [DATA_W-1:0]            rsp_rdata_o,
   output logic                         rsp_err_o,
   // status
   output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
   output logic                         proto_err_o
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTST+1);
   localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST-1);

   logic                 req_q,   req_d;
   logic                 we_q,    we_d;
   logic [BE_BITS-1:0]   be_q,    be_d;
   logic [ADDR_W-1:0]    addr_q,  addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [CNT_W-1:0]     cnt_q,   cnt_d;
   logic [PTR_W-1:0]     wptr_q,  wptr_d;
   logic [PTR_W-1:0]     rptr_q,  rptr_d;
   logic [MAX_OUTST-1:0] tag_q,   tag_d;
   logic                 perr_q,  perr_d;

   logic issue;
   logic accept;
   logic load;

   // req_o depends only on registered state, so it cannot drop before gnt_i
   assign req_o      = req_q & (cnt_q < CNT_MAX);
   assign issue      = req_o & gnt_i;
   assign host_rdy_o = ~req_q | issue;
   assign load       = host_req_i & host_rdy_o;
   // beats arriving with nothing outstanding are not responses
   assign accept     = rvalid_i & (cnt_q != '0);

   assign we_o        = we_q;
   assign be_o        = be_q;
   assign addr_o      = addr_q;
   assign wdata_o     = wdata_q;
   assign rsp_valid_o = accept;
   assign rsp_we_o    = tag_q[rptr_q];
   assign rsp_rdata_o = rdata_i;
   assign rsp_err_o   = err_i;
   assign outst_o     = cnt_q;
   assign proto_err_o = perr_q;

   // next-state: request register, outstanding count, tag FIFO, sticky error
   always_comb begin
      req_d   = req_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      tag_d   = tag_q;
      perr_d  = perr_q;

      if (load) begin
         req_d   = 1'b1;
         we_d    = host_we_i;
         be_d    = host_be_i;
         addr_d  = host_addr_i;
         wdata_d = host_wdata_i;
      end else if (issue) begin
         req_d = 1'b0;
      end

      unique case ({issue, accept})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      if (issue) begin
         tag_d[wptr_q] = we_q;
         wptr_d        = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      end
      if (accept) begin
         rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
      end

      if (rvalid_i && (cnt_q == '0)) begin
         perr_d = 1'b1;
      end
   end

   // state register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         tag_q   <= '0;
         perr_q  <= 1'b0;
      end else begin
         req_q   <= req_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         tag_q   <= tag_d;
         perr_q  <= perr_d;
      end
   end

endmodule
